// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared state enum, window bit indices and window assembly for the morph window sequencer
package morph_pkg;

  localparam int WIN_BITS = 9;

  localparam int WIN_TL = 0;
  localparam int WIN_T  = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_L  = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_R  = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_B  = 7;
  localparam int WIN_BR = 8;

  typedef enum logic [2:0] {IDLE, FILL, RUN, EOL, FLUSH} state_t;

  // Columns are {bottom, middle, top}. Rows are resolved before columns so
  // that replicated corners take the nearest in-image pixel.
  function automatic logic [WIN_BITS-1:0] build_window(
    input logic [2:0] lft,
    input logic [2:0] ctr,
    input logic [2:0] rgt,
    input logic       top_out,
    input logic       bot_out,
    input logic       left_out,
    input logic       right_out,
    input logic       rep
  );
    logic [2:0] l;
    logic [2:0] c;
    logic [2:0] r;
    logic [WIN_BITS-1:0] w;
    l = lft;
    c = ctr;
    r = rgt;
    if (top_out) begin
      l[0] = rep & l[1];
      c[0] = rep & c[1];
      r[0] = rep & r[1];
    end
    if (bot_out) begin
      l[2] = rep & l[1];
      c[2] = rep & c[1];
      r[2] = rep & r[1];
    end
    if (left_out)  l = rep ? c : 3'b000;
    if (right_out) r = rep ? c : 3'b000;
    w[WIN_TL] = l[0];
    w[WIN_T]  = c[0];
    w[WIN_TR] = r[0];
    w[WIN_L]  = l[1];
    w[WIN_C]  = c[1];
    w[WIN_R]  = r[1];
    w[WIN_BL] = l[2];
    w[WIN_B]  = c[2];
    w[WIN_BR] = r[2];
    return w;
  endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// rtl/morph_line_buffer.sv - 1-bit single-port line buffer, asynchronous read so the old value is read before the write at the same address
module morph_line_buffer
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10
)
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wr_data,
  output logic          rd_data
);

  logic mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/morph_window_ctrl.sv
// rtl/morph_window_ctrl.sv - raster 3x3 window sequencer for the binary morph filter
// Border: zero by default, edge replication when MORPH_BORDER_REPLICATE_EN is defined.
module morph_window_ctrl
  import morph_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                pix_in_valid,
  input  logic                pix_in,
  output logic                pix_in_ready,
  output logic                window_valid,
  output logic [WIN_BITS-1:0] binary_window,
  output logic [ROW_W-1:0]    win_row,
  output logic [COL_W-1:0]    win_col,
  output logic                frame_done,
  output logic                busy
);

  localparam int LB_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROWS     = ROW_W'(IMG_HEIGHT);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
`ifdef MORPH_BORDER_REPLICATE_EN
  localparam logic REPLICATE = 1'b1;
`else
  localparam logic REPLICATE = 1'b0;
`endif

  state_t           state;
  logic [ROW_W-1:0] in_row;
  logic [COL_W-1:0] in_col;
  logic [COL_W-1:0] fcol;
  logic [LB_AW-1:0] lb_addr;
  logic [2:0]       col_a;
  logic [2:0]       col_b;
  logic [2:0]       col_n;
  logic             lb_prev_rd;
  logic             lb_curr_rd;
  logic             accept;
  logic             lb_we;

  assign pix_in_ready = (state == IDLE) || (state == FILL) || (state == RUN);
  assign accept       = pix_in_valid && pix_in_ready;
  assign lb_we        = accept && (frame_start || (state != IDLE));
  assign col_n        = {pix_in, lb_curr_rd, lb_prev_rd};

  // EOL preloads column 0 for the flush; FLUSH reads one column ahead of the window centre.
  always_comb begin
    lb_addr = frame_start ? '0 : LB_AW'(in_col);
    if (state == EOL) lb_addr = '0;
    else if (state == FLUSH) lb_addr = (fcol == LAST_COL) ? '0 : LB_AW'(fcol + COL_W'(1));
  end

  morph_line_buffer #(.DEPTH(IMG_WIDTH), .AW(LB_AW)) u_lb_prev (
    .clk     (clk),
    .we      (lb_we),
    .addr    (lb_addr),
    .wr_data (lb_curr_rd),
    .rd_data (lb_prev_rd)
  );

  morph_line_buffer #(.DEPTH(IMG_WIDTH), .AW(LB_AW)) u_lb_curr (
    .clk     (clk),
    .we      (lb_we),
    .addr    (lb_addr),
    .wr_data (pix_in),
    .rd_data (lb_curr_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      window_valid  <= 1'b0;
      binary_window <= '0;
      win_row       <= '0;
      win_col       <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      in_row        <= '0;
      in_col        <= '0;
      fcol          <= '0;
      col_a         <= '0;
      col_b         <= '0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE, FILL, RUN: begin
          if (accept) begin
            if (frame_start) begin
              state  <= FILL;
              busy   <= 1'b1;
              in_row <= '0;
              in_col <= COL_W'(1);
              col_a  <= col_b;
              col_b  <= col_n;
            end else if (state != IDLE) begin
              col_a <= col_b;
              col_b <= col_n;
              if (in_col == LAST_COL) begin
                in_col <= '0;
                in_row <= in_row + ROW_W'(1);
              end else begin
                in_col <= in_col + COL_W'(1);
              end
              // Pixel (r+1,c+1) completes the window centred at (r,c).
              if ((in_row != '0) && (in_col != '0)) begin
                window_valid  <= 1'b1;
                binary_window <= build_window(col_a, col_b, col_n, in_row == ROW_W'(1), 1'b0,
                                              in_col == COL_W'(1), 1'b0, REPLICATE);
                win_row       <= in_row - ROW_W'(1);
                win_col       <= in_col - COL_W'(1);
              end
              if ((state == FILL) && (in_row == ROW_W'(1)) && (in_col == COL_W'(1))) state <= RUN;
              if ((state == RUN) && (in_col == LAST_COL)) state <= EOL;
            end
          end
        end
        EOL: begin
          window_valid  <= 1'b1;
          binary_window <= build_window(col_a, col_b, col_n, in_row == ROW_W'(2), 1'b0,
                                        1'b0, 1'b1, REPLICATE);
          win_row       <= in_row - ROW_W'(2);
          win_col       <= LAST_COL;
          if (in_row == ROWS) begin
            state <= FLUSH;
            fcol  <= '0;
            col_a <= col_b;
            col_b <= col_n;
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          window_valid  <= 1'b1;
          binary_window <= build_window(col_a, col_b, col_n, 1'b0, 1'b1,
                                        fcol == '0, fcol == LAST_COL, REPLICATE);
          win_row       <= LAST_ROW;
          win_col       <= fcol;
          col_a         <= col_b;
          col_b         <= col_n;
          if (fcol == LAST_COL) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            fcol <= fcol + COL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_window_ctrl.sv
// tb/tb_morph_window_ctrl.sv - scoreboard bench for morph_window_ctrl on a 4x3 image
module tb_morph_window_ctrl;
  import morph_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 3;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_in_valid;
  logic          pix_in;
  logic          pix_in_ready;
  logic          window_valid;
  logic [8:0]    binary_window;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;
  logic          busy;

  always #5 clk = ~clk;

  morph_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .pix_in_valid  (pix_in_valid),
    .pix_in        (pix_in),
    .pix_in_ready  (pix_in_ready),
    .window_valid  (window_valid),
    .binary_window (binary_window),
    .win_row       (win_row),
    .win_col       (win_col),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  typedef struct {
    logic [8:0] win;
    int         row;
    int         col;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   first_wv = -1;
  int   fd_cyc   = -1;
  int   low_cnt  = 0;

  // Hand-derived windows of an all-ones 4x3 frame with zero border, raster order
  logic [8:0] ones_zero [12] = '{9'h1B0, 9'h1F8, 9'h1F8, 9'h0D8,
                                 9'h1B6, 9'h1FF, 9'h1FF, 9'h0DB,
                                 9'h036, 9'h03F, 9'h03F, 9'h01B};
  // Single 1 at (1,1): it sits at bit 3*(2-r)+(2-c) of every window with c<=2
  logic [8:0] single [12]    = '{9'h100, 9'h080, 9'h040, 9'h000,
                                 9'h020, 9'h010, 9'h008, 9'h000,
                                 9'h004, 9'h002, 9'h001, 9'h000};

  function automatic logic [8:0] ones_exp(input int i);
`ifdef MORPH_BORDER_REPLICATE_EN
    return (i >= 0) ? 9'h1FF : 9'h000;
`else
    return ones_zero[i];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input bit ones);
    for (int i = 0; i < W * H; i++) begin
      exp_t e;
      e.win = ones ? ones_exp(i) : single[i];
      e.row = i / W;
      e.col = i % W;
      e.fd  = (i == W * H - 1);
      sb_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_pix(input logic p, input logic fs);
    int guard;
    guard        = 0;
    pix_in_valid = 1'b1;
    pix_in       = p;
    frame_start  = fs;
    while (!pix_in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!pix_in_ready) check("ready_timeout", 32'(pix_in_ready), 32'd1);
    acc_q.push_back(cyc);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!pix_in_ready) low_cnt++;
      if (window_valid) begin
        if (first_wv < 0) first_wv = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_window", 32'(window_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check($sformatf("window(%0d,%0d)", e.row, e.col), 32'(binary_window), 32'(e.win));
          check($sformatf("win_row(%0d,%0d)", e.row, e.col), 32'(win_row), 32'(e.row));
          check($sformatf("win_col(%0d,%0d)", e.row, e.col), 32'(win_col), 32'(e.col));
          check($sformatf("frame_done(%0d,%0d)", e.row, e.col), 32'(frame_done), 32'(e.fd));
        end
      end else if (frame_done) begin
        check("frame_done_without_window", 32'(frame_done), 32'd0);
      end
      if (frame_done) fd_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    frame_start  = 1'b0;
    pix_in_valid = 1'b0;
    pix_in       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(pix_in_ready), 32'd1);
    check("reset_window_valid", 32'(window_valid), 32'd0);
    check("reset_binary_window", 32'(binary_window), 32'd0);
    check("reset_win_row", 32'(win_row), 32'd0);
    check("reset_win_col", 32'(win_col), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // All-ones frame with continuous valid, plus cycle timing
    first_wv = -1;
    low_cnt  = 0;
    acc_q.delete();
    push_frame(1'b1);
    for (int i = 0; i < W * H; i++) send_pix(1'b1, i == 0);
    pix_in_valid = 1'b0;
    drain();
    check("first_window_latency", 32'(first_wv - acc_q[5]), 32'd1);
    check("eol_gap_after_accept8", 32'(acc_q[8] - acc_q[7]), 32'd2);
    check("row2_accepts_back_to_back", 32'(acc_q[11] - acc_q[8]), 32'd3);
    check("frame_done_latency", 32'(fd_cyc - acc_q[0]), 32'd18);
    check("ready_low_cycles", 32'(low_cnt), 32'd6);
    check("idle_busy", 32'(busy), 32'd0);

    // Single 1 at (1,1), valid dropped after every odd pixel
    push_frame(1'b0);
    for (int i = 0; i < W * H; i++) begin
      send_pix(i == 5, i == 0);
      if (i % 2 == 1) begin
        pix_in_valid = 1'b0;
        pix_in       = 1'b1;
        @(negedge clk);
      end
    end
    pix_in_valid = 1'b0;
    drain();

    // Abort: frame_start arrives where pixel (1,2) of an all-ones frame was due
    begin
      exp_t e;
      e.win = ones_exp(0);
      e.row = 0;
      e.col = 0;
      e.fd  = 1'b0;
      sb_q.push_back(e);
    end
    push_frame(1'b0);
    for (int i = 0; i < W + 2; i++) send_pix(1'b1, i == 0);
    for (int i = 0; i < W * H; i++) send_pix(i == 5, i == 0);
    pix_in_valid = 1'b0;
    drain();

    // Reset in the first FLUSH cycle
    for (int i = 0; i < 2 * W; i++) begin
      exp_t e;
      e.win = ones_exp(i);
      e.row = i / W;
      e.col = i % W;
      e.fd  = 1'b0;
      sb_q.push_back(e);
    end
    for (int i = 0; i < W * H; i++) send_pix(1'b1, i == 0);
    pix_in_valid = 1'b0;
    @(negedge clk);
    check("flush_ready_low", 32'(pix_in_ready), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_flush_state", 32'(dut.state), 32'(IDLE));
    check("rst_flush_ready", 32'(pix_in_ready), 32'd1);
    check("rst_flush_window_valid", 32'(window_valid), 32'd0);
    check("rst_flush_binary_window", 32'(binary_window), 32'd0);
    check("rst_flush_win_row", 32'(win_row), 32'd0);
    check("rst_flush_win_col", 32'(win_col), 32'd0);
    check("rst_flush_frame_done", 32'(frame_done), 32'd0);
    check("rst_flush_busy", 32'(busy), 32'd0);
    check("rst_flush_queue_empty", 32'(sb_q.size()), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
